obv_stat_snapshot: RTL and testbench
====================================

Name: obv_stat_snapshot

Overview:
- Parametrised bank of N_CH statistics counters (packet count, bytes, latency sum, ...) for the traffic-observer datapath.
- Supports pause, clear and sticky overflow flags.
- On request, captures all counters atomically into a shadow bank, then drains it as a valid/ready word stream, one channel per beat.
- Replaces the fixed seven-counter, always-streaming export with a coherent on-demand snapshot that downstream logic (AXI-Lite regfile or a CDC FIFO) consumes at its own pace.

Parameters:
- N_CH, 7, number of counter channels (>=1).
- CNT_W, 64, counter and shadow width in bits.
- INC_W, 16, per-channel increment width (<= CNT_W).
- CH_W, max(1,$clog2(N_CH)), localparam, width of the channel index.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- pause  in  1  freezes all increments while high.
- clear  in  1  synchronous clear of all counters and ovf flags.
- inc_vld  in  N_CH  per-channel increment enable.
- inc_val  in  N_CH*INC_W  per-channel increment amount; channel i occupies [i*INC_W +: INC_W].
- snap_req  in  1  snapshot request, sampled in IDLE only.
- snap_busy  out  1  high while a snapshot is held or streaming.
- m_vld  out  1  output beat valid.
- m_rdy  in  1  output beat ready.
- m_data  out  CNT_W  shadow value of channel m_ch.
- m_ch  out  CH_W  channel index of the current beat.
- m_last  out  1  high on the beat for channel N_CH-1.
- ovf  out  N_CH  sticky per-channel wrap flag.

Behaviour:
- Reset (rst_n low, asynchronous): all counters, shadows, ovf, m_ch, m_vld, m_last and snap_busy go to 0; FSM enters IDLE. m_data reads 0.
- Counter update at each edge, channel i, priority order:
  1. clear: cnt <= 0 and ovf[i] <= 0.
  2. Otherwise, if !pause && inc_vld[i]: cnt <= cnt + zero-extended inc_val, wrapping modulo 2^CNT_W. ovf[i] <= 1 on carry-out and stays set until clear or reset.
  3. Otherwise: hold.
- Counters keep updating in every FSM state. Snapshot activity never stalls counting.
- FSM states:
  - IDLE:
    - snap_busy = 0, m_vld = 0.
    - If snap_req is high at an edge: shadow[i] <= cnt[i] (register value before that edge's update), m_ch <= 0, go to STREAM.
  - STREAM:
    - snap_busy = 1, m_vld = 1, m_data = shadow[m_ch], m_last = (m_ch == N_CH-1).
    - On m_vld && m_rdy: if m_last, go to IDLE; else m_ch <= m_ch + 1.
    - m_rdy low holds m_data, m_ch and m_last stable.
- Latency: snap_req sampled at edge T, first beat valid from edge T onward (first cycle after T). Minimum full drain is N_CH cycles with m_rdy held high.
- snap_req while in STREAM is ignored; it is not queued.
- snap_req held continuously gives back-to-back snapshots: re-captured at the first edge back in IDLE, leaving exactly one idle cycle between streams.
- clear or pause during STREAM does not alter the shadows being streamed.
- clear and snap_req at the same edge: the snapshot holds the pre-clear values and the counters become 0.
- N_CH == 1: m_last is high on the single beat; m_ch is always 0.
- Reset asserted mid-stream aborts it immediately with no further beats. m_vld falls asynchronously.

Optional Feature:
- Macro: OBV_STAT_CLR_ON_SNAP_EN.
- Defined: at the capture edge each counter loads (!pause && inc_vld[i]) ? inc_val : 0 instead of accumulating, so no event is lost or double-counted across snapshots; ovf flags also clear at that edge. An explicit clear still overrides, loading 0.
- Undefined: counters keep accumulating through capture; only clear or reset zero them.

Test Plan:
- Reset then snapshot: rst_n low, then high; pulse snap_req with m_rdy=1 -> N_CH beats, all m_data=0, m_ch 0..6, m_last only on m_ch=6, snap_busy low the cycle after the last beat.
- Accumulate and capture: channel 2 receives inc_val=100 for 5 cycles, then snap_req -> beat m_ch=2 has m_data=500 and all other beats are 0. Further increments during the stream do not change the streamed values.
- Backpressure: drive m_rdy as 1,0,0,1,... during a stream -> each beat holds stable while m_rdy=0, no beat is skipped or duplicated, snap_req during STREAM produces no extra stream.
- Wrap: CNT_W=8, preload channel 0 to 250, add 10 -> counter = 4 and ovf[0]=1. ovf stays set after a further add; clear -> counter 0 and ovf 0.
- Simultaneous clear+snap_req with channel 1 = 77 -> beat m_ch=1 shows 77, and the counter reads 0 in the next snapshot. With pause high, inc_vld is ignored and the counter is unchanged.
- OBV_STAT_CLR_ON_SNAP_EN defined: channel 0 = 40, inc_val=3 asserted at the capture edge -> beat shows 40, next snapshot with no further increments shows 3.

Source files
------------

// File: rtl/obv_stat_snapshot.sv
// obv_stat_snapshot: N_CH stat counters, atomic shadow snapshot drained one channel per valid/ready beat; OBV_STAT_CLR_ON_SNAP_EN restarts counters at capture.
module obv_stat_snapshot #(
    parameter int N_CH = 7,
    parameter int CNT_W = 64,
    parameter int INC_W = 16,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pause,
    input  logic                  clear,
    input  logic [N_CH-1:0]       inc_vld,
    input  logic [N_CH*INC_W-1:0] inc_val,
    input  logic                  snap_req,
    output logic                  snap_busy,
    output logic                  m_vld,
    input  logic                  m_rdy,
    output logic [CNT_W-1:0]      m_data,
    output logic [CH_W-1:0]       m_ch,
    output logic                  m_last,
    output logic [N_CH-1:0]       ovf
);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [CNT_W-1:0] shadow_q [N_CH];
    logic [CNT_W:0]   sum [N_CH];
    logic [N_CH-1:0]  ovf_q, ovf_d;
    logic [CH_W-1:0]  m_ch_q;
    logic             m_vld_q, m_last_q, busy_q, capture;
    assign capture = (state_q == IDLE) && snap_req;
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            sum[i] = {1'b0, cnt_q[i]} + (CNT_W+1)'(inc_val[i*INC_W +: INC_W]);
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (clear) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end
`ifdef OBV_STAT_CLR_ON_SNAP_EN
            else if (capture) begin
                cnt_d[i] = (!pause && inc_vld[i]) ? CNT_W'(inc_val[i*INC_W +: INC_W]) : '0;
                ovf_d[i] = 1'b0;
            end
`endif
            else if (!pause && inc_vld[i]) begin
                cnt_d[i] = sum[i][CNT_W-1:0];
                ovf_d[i] = ovf_q[i] | sum[i][CNT_W];
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
    // Shadow is only written at capture, so counting, clear and pause never disturb a stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) shadow_q[i] <= '0;
            state_q  <= IDLE;
            m_ch_q   <= '0;
            m_vld_q  <= 1'b0;
            m_last_q <= 1'b0;
            busy_q   <= 1'b0;
        end else if (state_q == IDLE) begin
            if (snap_req) begin
                shadow_q <= cnt_q;
                state_q  <= STREAM;
                m_ch_q   <= '0;
                m_vld_q  <= 1'b1;
                m_last_q <= (N_CH == 1);
                busy_q   <= 1'b1;
            end
        end else if (m_rdy) begin
            if (m_last_q) begin
                state_q  <= IDLE;
                m_vld_q  <= 1'b0;
                m_last_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                m_ch_q   <= m_ch_q + CH_W'(1);
                m_last_q <= (m_ch_q + CH_W'(1)) == CH_W'(N_CH - 1);
            end
        end
    end
    assign m_data    = shadow_q[m_ch_q];
    assign m_ch      = m_ch_q;
    assign m_vld     = m_vld_q;
    assign m_last    = m_last_q;
    assign snap_busy = busy_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_obv_stat_snapshot.sv
// tb_obv_stat_snapshot: directed checks of the default bank plus an 8-bit bank for wrap/ovf.
module tb_obv_stat_snapshot;
    localparam int N = 7;
    logic clk = 1'b0, rst_n = 1'b1, pause = 1'b0, clear = 1'b0, snap_req = 1'b0, m_rdy = 1'b0;
    logic [N-1:0] inc_vld = '0;
    logic [N*16-1:0] inc_val = '0;
    logic snap_busy, m_vld, m_last;
    logic [63:0] m_data;
    logic [2:0] m_ch;
    logic [N-1:0] ovf;
    logic s_clear = 1'b0, s_snap = 1'b0, s_rdy = 1'b0;
    logic [1:0] s_inc_vld = '0;
    logic [15:0] s_inc_val = '0;
    logic s_busy, s_vld, s_last;
    logic [7:0] s_data;
    logic [0:0] s_ch;
    logic [1:0] s_ovf;
    logic [63:0] exp_v [N];
    int total = 0, bad = 0, k;

    obv_stat_snapshot dut (
        .clk(clk), .rst_n(rst_n), .pause(pause), .clear(clear), .inc_vld(inc_vld), .inc_val(inc_val),
        .snap_req(snap_req), .snap_busy(snap_busy), .m_vld(m_vld), .m_rdy(m_rdy), .m_data(m_data),
        .m_ch(m_ch), .m_last(m_last), .ovf(ovf)
    );
    obv_stat_snapshot #(.N_CH(2), .CNT_W(8), .INC_W(8)) sdut (
        .clk(clk), .rst_n(rst_n), .pause(1'b0), .clear(s_clear), .inc_vld(s_inc_vld), .inc_val(s_inc_val),
        .snap_req(s_snap), .snap_busy(s_busy), .m_vld(s_vld), .m_rdy(s_rdy), .m_data(s_data),
        .m_ch(s_ch), .m_last(s_last), .ovf(s_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input logic [63:0] e [N], input bit with_clr, input bit drop_inc);
        snap_req = 1'b1;
        clear = with_clr;
        m_rdy = 1'b1;
        tick;
        snap_req = 1'b0;
        clear = 1'b0;
        if (drop_inc) inc_vld = '0;
        for (int j = 0; j < N; j++) begin
            chk("beat_vld", m_vld, 1);
            chk("beat_busy", snap_busy, 1);
            chk("beat_ch", m_ch, j);
            chk("beat_data", m_data, e[j]);
            chk("beat_last", m_last, j == N - 1);
            tick;
        end
        chk("end_vld", m_vld, 0);
        chk("end_busy", snap_busy, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #10;
        chk("rst_vld", m_vld, 0);
        chk("rst_busy", snap_busy, 0);
        chk("rst_ch", m_ch, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk) rst_n = 1'b1;
        tick;
        exp_v = '{default: '0};
        drain(exp_v, 1'b0, 1'b0);

        inc_val[2*16 +: 16] = 16'd100;
        inc_vld[2] = 1'b1;
        repeat (5) tick;
        exp_v[2] = 64'd500;
        drain(exp_v, 1'b0, 1'b0);
        inc_vld = '0;
`ifdef OBV_STAT_CLR_ON_SNAP_EN
        exp_v[2] = 64'd800;
`else
        exp_v[2] = 64'd1300;
`endif
        drain(exp_v, 1'b0, 1'b0);
        clear = 1'b1;
        tick;
        clear = 1'b0;

        inc_val[4*16 +: 16] = 16'd9;
        inc_vld[4] = 1'b1;
        tick;
        inc_vld = '0;
        exp_v = '{default: '0};
        exp_v[4] = 64'd9;
        snap_req = 1'b1;
        m_rdy = 1'b0;
        tick;
        snap_req = 1'b0;
        k = 0;
        for (int c = 0; c < 25 && k < N; c++) begin
            m_rdy = (c % 3 == 0);
            snap_req = (c == 1 || c == 2);
            chk("bp_vld", m_vld, 1);
            chk("bp_ch", m_ch, k);
            chk("bp_data", m_data, exp_v[k]);
            chk("bp_last", m_last, k == N - 1);
            tick;
            if (m_rdy) k++;
        end
        snap_req = 1'b0;
        chk("bp_count", k, N);
        chk("bp_end_vld", m_vld, 0);
        tick;
        chk("bp_noextra", m_vld, 0);

        snap_req = 1'b1;
        m_rdy = 1'b1;
        tick;
        repeat (N) tick;
        chk("b2b_gap_vld", m_vld, 0);
        chk("b2b_gap_busy", snap_busy, 0);
        tick;
        snap_req = 1'b0;
        chk("b2b_restart_vld", m_vld, 1);
        chk("b2b_restart_ch", m_ch, 0);
        repeat (N) tick;
        chk("b2b_done", m_vld, 0);

        clear = 1'b1;
        tick;
        clear = 1'b0;
        inc_val[1*16 +: 16] = 16'd77;
        inc_vld[1] = 1'b1;
        tick;
        inc_vld = '0;
        exp_v = '{default: '0};
        exp_v[1] = 64'd77;
        drain(exp_v, 1'b1, 1'b0);
        pause = 1'b1;
        inc_val[1*16 +: 16] = 16'd5;
        inc_vld[1] = 1'b1;
        repeat (3) tick;
        pause = 1'b0;
        inc_vld = '0;
        exp_v = '{default: '0};
        drain(exp_v, 1'b0, 1'b0);

        clear = 1'b1;
        tick;
        clear = 1'b0;
        inc_val[0 +: 16] = 16'd40;
        inc_vld[0] = 1'b1;
        tick;
        inc_val[0 +: 16] = 16'd3;
        exp_v[0] = 64'd40;
        drain(exp_v, 1'b0, 1'b1);
`ifdef OBV_STAT_CLR_ON_SNAP_EN
        exp_v[0] = 64'd3;
`else
        exp_v[0] = 64'd43;
`endif
        drain(exp_v, 1'b0, 1'b0);

        s_inc_val[7:0] = 8'd250;
        s_inc_vld[0] = 1'b1;
        tick;
        chk("wrap_pre_ovf", s_ovf, 2'b00);
        s_inc_val[7:0] = 8'd10;
        tick;
        chk("wrap_ovf", s_ovf, 2'b01);
        s_inc_val[7:0] = 8'd1;
        tick;
        s_inc_vld = '0;
        chk("wrap_sticky", s_ovf, 2'b01);
        s_snap = 1'b1;
        s_rdy = 1'b1;
        tick;
        s_snap = 1'b0;
        chk("wrap_data0", s_data, 8'd5);
        chk("wrap_ch0", s_ch, 0);
        chk("wrap_last0", s_last, 0);
        tick;
        chk("wrap_data1", s_data, 8'd0);
        chk("wrap_last1", s_last, 1);
        tick;
        chk("wrap_end", s_vld, 0);
        s_clear = 1'b1;
        tick;
        s_clear = 1'b0;
        chk("wrap_clr_ovf", s_ovf, 2'b00);
        s_snap = 1'b1;
        tick;
        s_snap = 1'b0;
        chk("wrap_clr_data", s_data, 8'd0);
        tick;
        tick;
        chk("wrap_clr_end", s_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
